// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore-FSM control unit for the multicycle ARM-subset core.
// Define MULTICYCLE_CTRL_PERF_EN to add the InstrRetired retired-instruction counter.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  Cond,
  input  logic [1:0]  Op,
  input  logic [5:0]  Funct,
  input  logic [3:0]  Rd,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        IRWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] InstrRetired
`endif
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB,
    S_MEMWR, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
  } state_e;

  state_e     state, state_next;
  logic [3:0] flags;          // {N,Z,C,V}
  logic       cond_ex;
  logic       reg_w, mem_w, ir_w, next_pc, branch, alu_dec;
  logic [1:0] alu_decoded;
  logic       cmd_valid;
  logic [1:0] flag_w;
  logic [3:0] cmd;
  logic       s_bit;
  logic       n_f, z_f, c_f, v_f;

  assign cmd   = Funct[4:1];
  assign s_bit = Funct[0];
  assign {n_f, z_f, c_f, v_f} = flags;

  // Condition evaluated against the stored flags, so an instruction never sees
  // its own flag update.
  always_comb begin
    case (Cond)
      4'b0000: cond_ex = z_f;
      4'b0001: cond_ex = ~z_f;
      4'b0010: cond_ex = c_f;
      4'b0011: cond_ex = ~c_f;
      4'b0100: cond_ex = n_f;
      4'b0101: cond_ex = ~n_f;
      4'b0110: cond_ex = v_f;
      4'b0111: cond_ex = ~v_f;
      4'b1000: cond_ex = c_f & ~z_f;
      4'b1001: cond_ex = ~c_f | z_f;
      4'b1010: cond_ex = (n_f == v_f);
      4'b1011: cond_ex = (n_f != v_f);
      4'b1100: cond_ex = ~z_f & (n_f == v_f);
      4'b1101: cond_ex = z_f | (n_f != v_f);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    cmd_valid = 1'b1;
    case (cmd)
      4'b0100: alu_decoded = 2'b00;
      4'b0010: alu_decoded = 2'b01;
      4'b0000: alu_decoded = 2'b10;
      4'b1100: alu_decoded = 2'b11;
      default: begin
        alu_decoded = 2'b00;
        cmd_valid   = 1'b0;
      end
    endcase
  end

  // C and V only follow the ALU for arithmetic commands.
  assign flag_w = {s_bit, s_bit & ((cmd == 4'b0100) | (cmd == 4'b0010))};

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_next = state;
    ir_w       = 1'b0;
    next_pc    = 1'b0;
    reg_w      = 1'b0;
    mem_w      = 1'b0;
    branch     = 1'b0;
    alu_dec    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    case (state)
      S_FETCH: begin
        ir_w       = 1'b1;
        next_pc    = 1'b1;
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01:   state_next = S_MEMADR;
          2'b00:   state_next = Funct[5] ? S_EXECI : S_EXECR;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        AdrSrc     = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        reg_w      = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        AdrSrc     = 1'b1;
        mem_w      = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECR: begin
        alu_dec    = 1'b1;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        alu_dec    = 1'b1;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w      = cmd_valid;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcB    = 2'b01;
        ResultSrc  = 2'b10;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  assign ALUControl = alu_dec ? alu_decoded : 2'b00;
  assign ImmSrc     = Op;
  assign RegSrc     = {Op == 2'b01, Op == 2'b10};

  // Write enables are masked by reset so an aborted instruction cannot commit.
  assign IRWrite  = ~reset & ir_w;
  assign RegWrite = ~reset & reg_w & cond_ex;
  assign MemWrite = ~reset & mem_w & cond_ex;
  assign PCWrite  = ~reset & (next_pc | (branch & cond_ex) |
                              (reg_w & cond_ex & (Rd == 4'hF)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
      flags <= 4'b0000;
    end else begin
      state <= state_next;
      if (alu_dec && cond_ex) begin
        if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire;
  assign retire = (state == S_MEMWB) | (state == S_MEMWR) |
                  (state == S_ALUWB) | (state == S_BRANCH);

  always_ff @(posedge clk) begin
    if (reset)       InstrRetired <= 32'd0;
    else if (retire) InstrRetired <= InstrRetired + 32'd1;
  end
`endif

endmodule
